addsub_seq: RTL
===============

# addsub_seq

Parametrised multi-cycle adder/subtractor for the processor datapath, generalising the fixed 8-bit ripple add/sub unit. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a registered inter-chunk carry, and produces result, carry, signed-overflow and zero flags. A start/busy/done handshake lets the control unit issue operations and wait for completion.

## Interface

- WIDTH, 8, operand/result width in bits; ≥ 2
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH, WIDTH % CHUNK == 0 (elaboration error otherwise)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; latched with operands
- a  in  WIDTH  operand A; latched on accepted start
- b  in  WIDTH  operand B; latched on accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: result/flags just updated
- s  out  WIDTH  result, held until next completion
- co  out  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  s == 0

## Operation

- Arithmetic: s = A + (B XOR {WIDTH{sub}}) + sub, i.e. carry-in of chunk 0 equals sub; modulo 2^WIDTH.
- co = carry out of bit WIDTH−1; ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1; zero computed on final (post-saturation) s.
- NCH = WIDTH/CHUNK. Chunk i covers bits [i·CHUNK +: CHUNK], processed LSB chunk first.
- States: IDLE, RUN.
  - IDLE: busy=0. start=1 → latch a, b, sub; clear chunk counter; carry register ← sub; go RUN.
  - RUN: busy=1. Each cycle compute one chunk into an internal shadow result, update carry register, increment counter. On the cycle processing chunk NCH−1: write shadow to s, update co/ovf/zero, pulse done, go IDLE.
- s/co/ovf/zero change only at completion; partial results never visible.
- start while busy=1 is ignored (no queueing, no error).
- a, b, sub may change freely after acceptance.
- Reset (rst_n=0 at any edge, including mid-RUN): state → IDLE, operation aborted, no done pulse.

## Timing

- Reset values: busy=0, done=0, s=0, co=0, ovf=0, zero=0; counter and carry register 0.
- start sampled high at edge k in IDLE → busy=1 after edge k.
- Chunks processed at edges k+1 … k+NCH; after edge k+NCH: s/flags valid, done=1, busy=0.
- done high exactly one cycle (after edge k+NCH until edge k+NCH+1).
- Earliest next accepted start: edge k+NCH+1 (start may be high while done=1). Throughput one op per NCH+1 cycles.
- CHUNK=WIDTH: single RUN cycle, latency 1 cycle after acceptance.
- Counter width ceil(log2(NCH)), min 1; wraps never (reset to 0 on each accept).

## Configuration

- ADDSUB_SAT_EN defined: when ovf=1 at completion, s is clamped to signed saturation — 0 1…1 (most positive) if A's MSB is 0, 1 0…0 (most negative) if A's MSB is 1; ovf still reports 1, co reports the raw carry, zero computed on clamped value.
- Not defined: s always the wrapped modulo-2^WIDTH result; no saturation logic present.

## Test plan

- WIDTH=8, CHUNK=4; add 0x7F+0x01 → after 2 RUN edges done=1, s=0x80, co=0, ovf=1, zero=0; with ADDSUB_SAT_EN s=0x7F.
- Sub 0x05−0x05 → s=0x00, co=1, ovf=0, zero=1; sub 0x00−0x01 → s=0xFF, co=0, ovf=0, zero=0.
- Sub 0x80−0x01 → s=0x7F, co=1, ovf=1 (sat: s=0x80); add 0xFF+0x01 → s=0x00, co=1, ovf=0, zero=1.
- start with new operands on every cycle while busy → only the first accepted, single done, results match first op; start during done cycle accepted, next done exactly NCH+1 cycles after previous.
- Previous result s=0x12 held; start add 0x01+0x01, assert rst_n=0 after first RUN edge → no done, all outputs 0, busy=0; subsequent op completes correctly.
- Parameter sweep WIDTH=16 with CHUNK=1, 4, 16: random 1000 ops each vs. reference model, done latency exactly 16, 4, 1 cycles after acceptance.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed saturation of the result when ADDSUB_SAT_EN is defined.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("addsub_seq: invalid WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sub_q, sub_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

  int unsigned        base;
  logic [WIDTH-1:0]   b_eff;
  logic [CHUNK-1:0]   a_ch, b_ch;
  logic [CHUNK:0]     sum;
  logic               ovf_raw;
  logic [WIDTH-1:0]   s_fin;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    base  = int'(cnt_q) * CHUNK;
    b_eff = b_q ^ {WIDTH{sub_q}};
    a_ch  = a_q[base +: CHUNK];
    b_ch  = b_eff[base +: CHUNK];
    sum   = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(carry_q);
    // carry into the MSB is recovered as a^b^s of that bit, so no extra adder tap is needed
    ovf_raw = sum[CHUNK] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1];
    s_fin   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cnt_d   = '0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        shadow_d[base +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef ADDSUB_SAT_EN
          s_fin = ovf_raw ? (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}})
                          : shadow_d;
`else
          s_fin = shadow_d;
`endif
          s_d     = s_fin;
          co_d    = sum[CHUNK];
          ovf_d   = ovf_raw;
          zero_d  = (s_fin == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
